// File: rtl/mm_ctrl_pkg.sv
// Shared types and helpers for the PE-slice A-operand bank controller.
//   rd_state_t  : read sequencer state
//   bank_idx_t  : one-bit ping-pong bank index
//   at_terminal : true when a counter sits on its last value (limit-1)
package mm_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  typedef logic bank_idx_t;

  // Exact compare against the configured count; counts need not be powers of two.
  function automatic logic at_terminal(input int unsigned cnt, input int unsigned limit);
    return (cnt == (limit - 32'd1));
  endfunction

endpackage

// File: rtl/pingpong_bank_ctrl_rd_delay_pipe.sv
// Fixed-latency shift register that tracks SRAM read latency.
//   clk, rst : clock, asynchronous active-high reset (clears every stage)
//   i_d      : WIDTH-bit value entering the pipe this cycle
//   o_q      : value presented DEPTH cycles later
module rd_delay_pipe #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  // Shift one stage per cycle; never stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < int'(DEPTH); i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/pingpong_bank_ctrl.sv
// Ping-pong scheduler for the two-bank A-operand SRAM in a PE slice.
// The loader is granted the next free bank; full banks are swept B_NUM times
// over PE_NUM rows for the MAC pipeline, and each bank is released on its last read.
//   clk, rst          : clock, asynchronous active-high reset
//   load_grant_out    : bank at load_bank_out is free for writing
//   load_bank_out     : bank index the loader uses as write-address MSB
//   load_done_in      : loader finished the granted bank (one-cycle pulse)
//   pe_ready_in       : MAC accepts a read this cycle
//   rd_en_out         : SRAM read enable
//   rd_addr_out       : {bank, row} read address
//   rd_valid_out      : read data valid (rd_en_out delayed RD_DELAY)
//   rd_last_out       : final read of a tile, aligned with rd_valid_out
//   tile_cnt_out      : tiles fully read, wrapping
//   protocol_err_out  : sticky, load_done_in seen without a grant
module pingpong_bank_ctrl
  import mm_ctrl_pkg::*;
#(
  parameter int unsigned PE_NUM_WIDTH   = 2,
  parameter int unsigned PE_NUM         = 4,
  parameter int unsigned B_NUM_WIDTH    = 2,
  parameter int unsigned B_NUM          = 4,
  parameter int unsigned RD_DELAY       = 2,
  parameter int unsigned TILE_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      load_grant_out,
  output logic                      load_bank_out,
  input  logic                      load_done_in,
  input  logic                      pe_ready_in,
  output logic                      rd_en_out,
  output logic [PE_NUM_WIDTH:0]     rd_addr_out,
  output logic                      rd_valid_out,
  output logic                      rd_last_out,
  output logic [TILE_CNT_WIDTH-1:0] tile_cnt_out,
  output logic                      protocol_err_out
);

  localparam int unsigned PIPE_W = 2;

  logic [1:0]                r_bank_full;
  bank_idx_t                 r_load_ptr;
  bank_idx_t                 r_read_ptr;
  logic [PE_NUM_WIDTH-1:0]   r_row;
  logic [B_NUM_WIDTH-1:0]    r_col;
  rd_state_t                 r_state;
  logic [TILE_CNT_WIDTH-1:0] r_tile_cnt;
  logic                      r_prot_err;

  rd_state_t                 w_state_nxt;
  logic [PE_NUM_WIDTH-1:0]   w_row_nxt;
  logic [B_NUM_WIDTH-1:0]    w_col_nxt;
  logic                      w_grant;
  logic                      w_load_accept;
  logic                      w_rd_fire;
  logic                      w_row_term;
  logic                      w_col_term;
  logic                      w_last;
  bank_idx_t                 w_other;
  logic                      w_read_bank_ready;
  logic                      w_other_bank_ready;
  logic [1:0]                w_set_mask;
  logic [1:0]                w_clr_mask;
  logic [PIPE_W-1:0]         w_pipe_q;

  // Load side: grant while the pointed-to bank is empty.
  assign w_grant       = ~r_bank_full[r_load_ptr];
  assign w_load_accept = load_done_in & w_grant;

  // Read side terminal counts and tile-final read.
  assign w_rd_fire  = (r_state == READ) & pe_ready_in;
  assign w_row_term = at_terminal(32'(r_row), PE_NUM);
  assign w_col_term = at_terminal(32'(r_col), B_NUM);
  assign w_last     = w_rd_fire & w_row_term & w_col_term;
  assign w_other    = ~r_read_ptr;

  // A bank counts as ready if already full or being filled at this same edge,
  // so reading can start the cycle after load_done_in and tiles chain without bubbles.
  assign w_read_bank_ready  = r_bank_full[r_read_ptr] |
                              (w_load_accept & (r_load_ptr == r_read_ptr));
  assign w_other_bank_ready = r_bank_full[w_other] |
                              (w_load_accept & (r_load_ptr == w_other));

  assign w_set_mask[0] = w_load_accept & (r_load_ptr == 1'b0);
  assign w_set_mask[1] = w_load_accept & (r_load_ptr == 1'b1);
  assign w_clr_mask[0] = w_last & (r_read_ptr == 1'b0);
  assign w_clr_mask[1] = w_last & (r_read_ptr == 1'b1);

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // Read FSM next state and row/column sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    case (r_state)
      IDLE: begin
        if (w_read_bank_ready) begin
          w_state_nxt = READ;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end
      end
      READ: begin
        if (w_rd_fire) begin
          if (w_row_term) begin
            w_row_nxt = '0;
            if (w_col_term) begin
              w_col_nxt = '0;
              if (!w_other_bank_ready) w_state_nxt = IDLE;
            end else begin
              w_col_nxt = B_NUM_WIDTH'(r_col + 1'b1);
            end
          end else begin
            w_row_nxt = PE_NUM_WIDTH'(r_row + 1'b1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bank bookkeeping, pointers, tile counter and sticky protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank_full <= '0;
      r_load_ptr  <= 1'b0;
      r_read_ptr  <= 1'b0;
      r_tile_cnt  <= '0;
      r_prot_err  <= 1'b0;
    end else begin
      r_bank_full <= (r_bank_full | w_set_mask) & ~w_clr_mask;
      if (w_load_accept) r_load_ptr <= ~r_load_ptr;
      if (w_last) begin
        r_read_ptr <= ~r_read_ptr;
        r_tile_cnt <= TILE_CNT_WIDTH'(r_tile_cnt + 1'b1);
      end
      if (load_done_in && !w_grant) r_prot_err <= 1'b1;
    end
  end

  // Valid/last follow the read enable by the SRAM latency.
  rd_delay_pipe #(
    .WIDTH(PIPE_W),
    .DEPTH(RD_DELAY)
  ) u_rd_delay_pipe (
    .clk (clk),
    .rst (rst),
    .i_d ({w_rd_fire, w_last}),
    .o_q (w_pipe_q)
  );

  assign load_grant_out   = w_grant;
  assign load_bank_out    = r_load_ptr;
  assign rd_en_out        = w_rd_fire;
  assign rd_addr_out      = {r_read_ptr, r_row};
  assign rd_valid_out     = w_pipe_q[1];
  assign rd_last_out      = w_pipe_q[0];
  assign tile_cnt_out     = r_tile_cnt;
  assign protocol_err_out = r_prot_err;

endmodule

// File: doc/pingpong_bank_ctrl.md
Name: pingpong_bank_ctrl

Overview:
- Schedules the two-bank (ping-pong) A-operand SRAM inside each PE slice.
- Grants the loader the bank it may fill next, then sequences read addresses out of full banks for the multiply pipeline.
- Frees each bank after its last read so loading and compute overlap.
- Sits between the per-PE load stage (SRAM write side) and the sdp_sram read port / MAC datapath.

Parameters:
- PE_NUM_WIDTH, 2, width of the in-bank row address.
- PE_NUM, 4, rows per bank (S_i/P); must be ≤ 2**PE_NUM_WIDTH.
- B_NUM_WIDTH, 2, width of the column-repeat counter.
- B_NUM, 4, times each bank is swept (S_j); must be ≤ 2**B_NUM_WIDTH.
- RD_DELAY, 2, SRAM read latency in cycles; must be ≥ 1.
- TILE_CNT_WIDTH, 8, width of the completed-tile counter.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: asynchronous, active-high.
- load_grant_out, output, 1, the bank at load_bank_out is free and may be written.
- load_bank_out, output, 1, bank index the loader must use as the SRAM write-address MSB.
- load_done_in, input, 1, one-cycle pulse: the loader finished writing the last row of the granted bank.
- pe_ready_in, input, 1, downstream MAC can accept a read this cycle.
- rd_en_out, output, 1, SRAM read enable.
- rd_addr_out, output, PE_NUM_WIDTH+1, {bank, row} read address.
- rd_valid_out, output, 1, SRAM data valid; equals rd_en_out delayed by RD_DELAY.
- rd_last_out, output, 1, marks the final read of a tile; aligned with rd_valid_out.
- tile_cnt_out, output, TILE_CNT_WIDTH, number of tiles fully read; wraps modulo 2**TILE_CNT_WIDTH.
- protocol_err_out, output, 1, sticky flag: load_done_in arrived while load_grant_out was low.

Behaviour:
- State: bank_full[1:0], load_ptr, read_ptr, row counter, column counter, read FSM.
- Reset (async): bank_full=0, load_ptr=0, read_ptr=0, FSM=IDLE, counters=0, delay pipes cleared. Outputs at reset:
  - load_grant_out=1, load_bank_out=0.
  - rd_en_out=0, rd_addr_out=0.
  - rd_valid_out=0, rd_last_out=0.
  - tile_cnt_out=0, protocol_err_out=0.
- load_grant_out = !bank_full[load_ptr] (combinational); load_bank_out = load_ptr.
- load_done_in && load_grant_out at edge: bank_full[load_ptr]<=1, load_ptr toggles.
- load_done_in && !load_grant_out: ignored (no state change); protocol_err_out<=1 until reset.
- Read FSM states IDLE, READ.
  - IDLE: if bank_full[read_ptr] then →READ with row=0, col=0. Earliest first rd_en_out is one cycle after the load_done_in edge.
  - READ: rd_en_out = pe_ready_in (combinational); rd_addr_out = {read_ptr, row}.
  - READ with pe_ready_in=0: counters hold, no read.
  - Each accepted read: row++. At row==PE_NUM-1, row<=0 and col++.
- Last read of a tile is row==PE_NUM-1 && col==B_NUM-1 accepted. On that edge:
  - bank_full[read_ptr]<=0; read_ptr toggles; tile_cnt_out++.
  - The rd_last pipe input is 1 for that read.
  - If the other bank is already full (or is set by load_done_in at the same edge), FSM stays in READ with zeroed counters: no bubble. Otherwise →IDLE.
- Total reads per tile = PE_NUM*B_NUM. Row sequence: 0..PE_NUM-1 repeated B_NUM times.
- Simultaneous events: load_done_in setting one bank and a last read clearing the other at the same edge → both updates apply.
  - Same-bank set and clear cannot coincide, because the grant is low while that bank is full.
- rd_valid_out / rd_last_out come from an RD_DELAY-deep shift register fed by rd_en_out / (rd_en_out && last). Not stalled by pe_ready_in.
- Reset mid-operation: everything returns to reset values, including in-flight valid bits; the partial tile is discarded.
- Counters compare against parameter values exactly; no power-of-two assumption.

Decomposition:
- Package mm_ctrl_pkg: rd_state_t enum {IDLE, READ}; typedef bank_idx_t (1 bit); shared helper for row/column terminal-count compare.
- Sub-module rd_delay_pipe (WIDTH, DEPTH, async reset to 0), instantiated once for {rd_valid, rd_last}.
- Everything else stays in pingpong_bank_ctrl.

Test Plan:
- Reset release → load_grant_out=1, load_bank_out=0, rd_en_out=0, tile_cnt_out=0, protocol_err_out=0.
- Single tile (PE_NUM=4, B_NUM=4, pe_ready_in=1), load_done_in pulse at cycle t:
  - From t+1: 16 consecutive rd_en_out with addrs {0,0},{0,1},{0,2},{0,3}×4.
  - rd_valid_out high cycles t+3..t+18; rd_last_out only at t+18.
  - tile_cnt_out=1; load_grant_out back to 1 with bank 1 still next.
- Ping-pong: load_done_in at t and t+1 → load_grant_out=0 after t+1. Bank 0 reads, then {1,0} directly after {0,3}-final with no gap. load_grant_out=1, load_bank_out=0 the cycle after bank 0's last read.
- Stall: pe_ready_in low for 3 cycles when row=2, col=1 → rd_en_out=0, rd_addr_out holds {0,2}, resumes with {0,2}; still 16 reads total.
- Protocol error: two load_done_in with no reads (both banks full), then third pulse → ignored, bank_full unchanged, protocol_err_out=1 and stays 1.
- Async reset asserted mid-tile with reads in flight → rd_valid_out=0 immediately, bank_full=0, grant=1 bank 0, tile_cnt_out=0.
